// File: rtl/alu_exec.sv
// Execute stage of the 16-bit RISC datapath: single-cycle ALU ops plus an
// optional iterative shift-and-add multiplier enabled by `define ALU_MUL_EN.
module alu_exec #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  dest,
    output logic        wb_valid,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [3:0]  flags,
    output logic        illegal
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SRA = 4'd8,
        OP_MOV = 4'd9,
        OP_CMP = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    // The multiplier walks one bit of b per cycle, so only 16 is meaningful.
    if (MUL_CYCLES != 16) begin : g_bad_mul_cycles
        $error("alu_exec: MUL_CYCLES must be 16");
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [15:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_wb;
    logic        alu_legal;
    logic [16:0] add_full;
    logic [15:0] sub_res;
    logic [16:0] shl_full;
    logic [16:0] shr_full;
    logic [16:0] sra_full;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_wb    = 1'b1;
        alu_legal = 1'b1;
        add_full  = {1'b0, a} + {1'b0, b};
        sub_res   = a - b;
        // An extra bit beside the operand captures the last bit shifted out.
        shl_full  = {1'b0, a} << b[3:0];
        shr_full  = {a, 1'b0} >> b[3:0];
        sra_full  = $signed({a, 1'b0}) >>> b[3:0];
        case (op)
            OP_ADD: begin
                alu_res = add_full[15:0];
                alu_c   = add_full[16];
                alu_v   = (a[15] == b[15]) && (add_full[15] != a[15]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_res;
                alu_c   = (a >= b);
                alu_v   = (a[15] != b[15]) && (sub_res[15] != a[15]);
                alu_wb  = (op != OP_CMP);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = shl_full[15:0];
                alu_c   = shl_full[16];
            end
            OP_SHR: begin
                alu_res = shr_full[16:1];
                alu_c   = shr_full[0];
            end
            OP_SRA: begin
                alu_res = sra_full[16:1];
                alu_c   = sra_full[0];
            end
            OP_MOV: alu_res = b;
            default: begin
                alu_legal = 1'b0;
                alu_wb    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers and control
    // ------------------------------------------------------------------
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_addr_q,  wb_addr_d;
    logic [15:0] wb_data_q,  wb_data_d;
    logic [3:0]  flags_q,    flags_d;
    logic        illegal_q,  illegal_d;
    logic        accept;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e             state_q,  state_d;
    logic [31:0]        mcand_q,  mcand_d;
    logic [15:0]        mplier_q, mplier_d;
    logic [31:0]        acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [3:0]         mdest_q,  mdest_d;

    assign in_ready = (state_q == S_IDLE);
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        illegal_d  = 1'b0;
`ifdef ALU_MUL_EN
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mdest_d    = mdest_q;

        if (state_q == S_MUL) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                state_d    = S_IDLE;
                wb_valid_d = 1'b1;
                wb_addr_d  = mdest_q;
                wb_data_d  = acc_d[15:0];
                flags_d    = {acc_d[15:0] == 16'd0, acc_d[15], |acc_d[31:16], 1'b0};
            end
        end else if (accept && op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {16'd0, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            mdest_d  = dest;
        end else
`endif
        if (accept) begin
            if (!alu_legal) begin
                illegal_d = 1'b1;
            end else begin
                flags_d = {alu_res == 16'd0, alu_res[15], alu_c, alu_v};
                if (alu_wb) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = dest;
                    wb_data_d  = alu_res;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            illegal_q  <= 1'b0;
`ifdef ALU_MUL_EN
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mdest_q    <= '0;
`endif
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
            illegal_q  <= illegal_d;
`ifdef ALU_MUL_EN
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mdest_q    <= mdest_d;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; MUL checks compile only when
// ALU_MUL_EN is defined, otherwise opcode 11 is checked as illegal.
module tb_alu_exec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_exec #(.MUL_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .dest     (dest),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flags    (flags),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op at the falling edge, let the rising edge take it, sample 1 ns later.
    task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        dest     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_addr"},  32'(wb_addr),  32'd0);
        check({tag, "_wb_data"},  32'(wb_data),  32'd0);
        check({tag, "_flags"},    32'(flags),    32'd0);
        check({tag, "_illegal"},  32'(illegal),  32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        op       = 4'd0;
        a        = 16'h1111;
        b        = 16'h2222;
        dest     = 4'd5;

        // Inputs toggling under reset must be ignored.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_release");

        // ADD with signed overflow: flags {Z,N,C,V} = 0101.
        issue(4'd0, 16'h7FFF, 16'h0001, 4'd3);
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_addr",  32'(wb_addr),  32'd3);
        check("add_wb_data",  32'(wb_data),  32'h8000);
        check("add_flags",    32'(flags),    32'b0101);

        // Back-to-back SUB then CMP.
        issue(4'd1, 16'h0005, 16'h0005, 4'd1);
        check("sub_wb_valid", 32'(wb_valid), 32'd1);
        check("sub_wb_addr",  32'(wb_addr),  32'd1);
        check("sub_wb_data",  32'(wb_data),  32'h0000);
        check("sub_flags",    32'(flags),    32'b1010);
        issue(4'd10, 16'h0003, 16'h0007, 4'd2);
        check("cmp_wb_valid", 32'(wb_valid), 32'd0);
        check("cmp_flags",    32'(flags),    32'b0100);
        check("cmp_addr_hold", 32'(wb_addr), 32'd1);
        check("cmp_data_hold", 32'(wb_data), 32'h0000);

        // Shifts.
        issue(4'd7, 16'h8001, 16'h0001, 4'd4);
        check("shr_wb_data", 32'(wb_data), 32'h4000);
        check("shr_flags",   32'(flags),   32'b0010);
        issue(4'd8, 16'h8000, 16'h0004, 4'd5);
        check("sra_wb_data", 32'(wb_data), 32'hF800);
        check("sra_flags",   32'(flags),   32'b0100);
        issue(4'd6, 16'h8001, 16'h0001, 4'd6);
        check("shl1_wb_data", 32'(wb_data), 32'h0002);
        check("shl1_flags",   32'(flags),   32'b0010);
        issue(4'd6, 16'h1234, 16'h0010, 4'd6);
        check("shl0_wb_data", 32'(wb_data), 32'h1234);
        check("shl0_flags",   32'(flags),   32'b0000);

        // Logic ops and MOV.
        issue(4'd4, 16'hFF00, 16'h0FF0, 4'd7);
        check("xor_wb_data", 32'(wb_data), 32'hF0F0);
        check("xor_flags",   32'(flags),   32'b0100);
        issue(4'd5, 16'hFFFF, 16'h0000, 4'd8);
        check("not_wb_data", 32'(wb_data), 32'h0000);
        check("not_flags",   32'(flags),   32'b1000);
        issue(4'd9, 16'h0000, 16'h00A5, 4'd9);
        check("mov_wb_addr", 32'(wb_addr), 32'd9);
        check("mov_wb_data", 32'(wb_data), 32'h00A5);
        check("mov_flags",   32'(flags),   32'b0000);

        // Illegal opcode 13: pulse, no writeback, flags held.
        issue(4'd13, 16'h0001, 16'h0001, 4'd12);
        check("ill13_illegal",  32'(illegal),  32'd1);
        check("ill13_wb_valid", 32'(wb_valid), 32'd0);
        check("ill13_flags",    32'(flags),    32'b0000);
        check("ill13_wb_addr",  32'(wb_addr),  32'd9);
        idle_cycle();
        check("ill13_pulse_end", 32'(illegal),  32'd0);
        check("idle_wb_valid",   32'(wb_valid), 32'd0);

`ifdef ALU_MUL_EN
        begin
            int low_cnt;
            int early_wb;
            low_cnt  = 0;
            early_wb = 0;
            // Accept edge k; after it, hold an ADD that must wait.
            issue(4'd11, 16'h0123, 16'h0100, 4'd10);
            for (int i = 0; i < 16; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end else begin
                    @(negedge clk);
                    op   = 4'd0;
                    a    = 16'h0001;
                    b    = 16'h0001;
                    dest = 4'd11;
                    #4;
                end
                if (!in_ready) low_cnt++;
                if (wb_valid)  early_wb++;
            end
            check("mul_ready_low_cycles", 32'(low_cnt),  32'd16);
            check("mul_early_wb",         32'(early_wb), 32'd0);
            @(posedge clk);
            #1;
            check("mul_wb_valid", 32'(wb_valid), 32'd1);
            check("mul_wb_addr",  32'(wb_addr),  32'd10);
            check("mul_wb_data",  32'(wb_data),  32'h2300);
            check("mul_flags",    32'(flags),    32'b0010);
            check("mul_ready_back", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check("held_add_wb_valid", 32'(wb_valid), 32'd1);
            check("held_add_wb_addr",  32'(wb_addr),  32'd11);
            check("held_add_wb_data",  32'(wb_data),  32'h0002);
        end

        // Reset pulsed during MUL iteration 8.
        begin
            int wb_seen;
            wb_seen = 0;
            issue(4'd11, 16'hFFFF, 16'hFFFF, 4'd12);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (wb_valid) wb_seen++;
            end
            @(negedge clk);
            reset = 1'b0;
            #1;
            check_reset_outputs("mid_mul_reset");
            repeat (2) begin
                @(posedge clk);
                #1;
                if (wb_valid) wb_seen++;
            end
            @(negedge clk);
            reset = 1'b1;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (wb_valid) wb_seen++;
            end
            check("aborted_mul_no_wb", 32'(wb_seen), 32'd0);
            issue(4'd0, 16'h0002, 16'h0003, 4'd13);
            check("post_reset_add_valid", 32'(wb_valid), 32'd1);
            check("post_reset_add_addr",  32'(wb_addr),  32'd13);
            check("post_reset_add_data",  32'(wb_data),  32'h0005);
            check("post_reset_add_flags", 32'(flags),    32'b0000);
        end
`else
        // Without the multiplier, opcode 11 is illegal and in_ready stays high.
        issue(4'd0, 16'h8000, 16'h8000, 4'd2);
        check("pre11_flags", 32'(flags), 32'b1011);
        issue(4'd11, 16'h0123, 16'h0100, 4'd10);
        check("ill11_illegal",  32'(illegal),  32'd1);
        check("ill11_wb_valid", 32'(wb_valid), 32'd0);
        check("ill11_flags",    32'(flags),    32'b1011);
        check("ill11_in_ready", 32'(in_ready), 32'd1);
        issue(4'd0, 16'h0002, 16'h0003, 4'd13);
        check("ill11_pulse_end", 32'(illegal),  32'd0);
        check("post11_add_data", 32'(wb_data),  32'h0005);
        check("post11_add_addr", 32'(wb_addr),  32'd13);
`endif

        idle_cycle();
        check("final_wb_valid", 32'(wb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 16-bit RISC datapath. Accepts operands read from the 16×16 register file with a valid/ready handshake, computes single-cycle ALU results or an iterative 16-cycle multiply, and emits a one-cycle writeback pulse. The writeback outputs drive the register file's write port (address, data, write enable) directly.

## Interface
Parameters:
- `MUL_CYCLES`, default 16: multiplier iterations (one per bit of `b`); fixed at 16 for 16-bit operands.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operation presented on `op`/`a`/`b`/`dest`.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `op`  in  4  opcode.
- `a`  in  16  operand A, from register-file read port 1.
- `b`  in  16  operand B, from register-file read port 2.
- `dest`  in  4  destination register address.
- `wb_valid`  out  1  writeback strobe; connects to the register-file write enable.
- `wb_addr`  out  4  writeback address; connects to the register-file write address.
- `wb_data`  out  16  writeback data; connects to the register-file write data.
- `flags`  out  4  {Z,N,C,V}, registered.
- `illegal`  out  1  one-cycle pulse on acceptance of an unsupported opcode.

## Operation
- Accept on a rising edge where `in_valid && in_ready`. Inputs are sampled only at acceptance.
- States:
  - IDLE: `in_ready`=1.
  - MUL: `in_ready`=0.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: a<<b[3:0].
  - 7 SHR: logical shift right, a>>b[3:0].
  - 8 SRA: arithmetic shift right, a>>>b[3:0].
  - 9 MOV: b.
  - 10 CMP: a−b, flags only, no writeback.
  - 11 MUL: low 16 bits of a×b.
  - 12–15: illegal.
- Single-cycle ops: stay in IDLE. The result is registered on the accept edge; `wb_valid`=1 for exactly one cycle, with `wb_addr`=`dest` and `wb_data`=result.
- MUL: IDLE→MUL on accept; the accept edge loads the multiplicand, the multiplier, acc=0 and count=0.
  - Each MUL-state edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge with count==15: register the result and the flags, pulse `wb_valid`, return to IDLE.
- Arithmetic is modulo 2^16.
- Flags, registered with the result:
  - Z = (result==0); N = result[15].
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = 1 when a ≥ b unsigned (no borrow); V = signed overflow.
  - Logic ops and MOV: C=0, V=0.
  - Shifts: C = last bit shifted out, 0 when the shift amount is 0; V=0.
  - MUL: C = (upper 16 bits of the 32-bit product ≠ 0); V=0.
- Illegal opcode: no writeback, `flags` unchanged, `illegal` pulses for one cycle, stay in IDLE.
- `wb_addr`/`wb_data` hold their last values while `wb_valid`=0.
- Read-after-write hazards against the register file are the issue logic's responsibility. This stage performs no forwarding.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`=1 (combinational from state).
  - `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `flags`=0, `illegal`=0.
- Inputs are ignored while `reset`=0.
- Single-cycle op accepted at edge k: `wb_valid` high in the cycle after edge k. Back-to-back accepts are allowed, giving throughput 1 op/cycle.
- MUL accepted at edge k:
  - `in_ready`=0 after edges k…k+15.
  - `wb_valid` is high and `in_ready`=1 in the cycle after edge k+16.
  - A new op may be accepted at edge k+17.
- `in_valid` held while `in_ready`=0 is not consumed. The operation is accepted on the first edge with `in_ready`=1.
- Reset asserted mid-MUL: abort immediately, no writeback, all outputs return to reset values.
- CMP produces `wb_valid`=0 but updates `flags` on the accept edge.

## Configuration
- `ALU_MUL_EN` defined: opcode 11 is implemented by the MUL state and iteration counter as described above.
- `ALU_MUL_EN` undefined: the MUL state, counter and accumulator are not compiled. Opcode 11 is illegal (`illegal` pulse, no writeback), and `in_ready` is constantly 1 outside reset.

## Test plan
- Reset: after release, all outputs 0 and `in_ready`=1. Then ADD a=0x7FFF, b=0x0001, dest=3 → one cycle later `wb_valid`=1, `wb_addr`=3, `wb_data`=0x8000, flags Z=0 N=1 C=0 V=1.
- Back-to-back issue of SUB 5−5 (dest 1) then CMP 3−7 → first cycle: `wb_data`=0, Z=1, C=1. Second cycle: `wb_valid`=0, flags Z=0 N=1 C=0 V=0.
- SHR a=0x8001, b=1 → `wb_data`=0x4000, C=1. SRA a=0x8000, b=4 → 0xF800. SHL with b[3:0]=0 → a unchanged, C=0.
- MUL a=0x0123, b=0x0100 (`ALU_MUL_EN` defined) →
  - `in_ready` low for 16 cycles, with `in_valid` held meanwhile not accepted;
  - `wb_data`=0x2300, C=1, accepted at edge k with `wb_valid` in the cycle after edge k+16.
- MUL a=0xFFFF, b=0xFFFF with reset pulsed low at iteration 8 → no `wb_valid` pulse, outputs reset, and the next ADD completes normally.
- Opcode 13, and opcode 11 with `ALU_MUL_EN` undefined → `illegal` pulses for 1 cycle, no writeback, `flags` unchanged.
